// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter that shares one framed serial TX line
// (start 0, N data bits LSB first, stop 1) between four requesters.
module serial_tx_arbiter #(
  parameter int unsigned N            = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic           clk,
  input  logic           reset_p,
  input  logic [3:0]     req,
  input  logic [4*N-1:0] data_flat,
  output logic [3:0]     gnt,
  output logic [3:0]     done,
  output logic           busy,
  output logic           tx
);

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned BIT_W   = $clog2(N + 1);
  localparam int unsigned TICK_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        rr_ptr;
  logic [1:0]        cur_idx;
  logic [1:0]        win_idx;
  logic [1:0]        cand;
  logic              win_valid;
  logic [N-1:0]      sreg;
  logic [N-1:0]      win_data;
  logic [BIT_W-1:0]  bit_cnt;
  logic [TICK_W-1:0] tick;
  logic              tick_last;

  // Round-robin search: first asserted request at or above the pointer, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = rr_ptr;
    cand      = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = rr_ptr + 2'(k);
      if (req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Word of the current search winner, captured only at the grant edge.
  always_comb begin
    win_data = data_flat[int'(win_idx) * N +: N];
  end

  assign tick_last = (tick == TICK_W'(CLKS_PER_BIT - 1));

  // Frame sequencer; gnt/done default low so they pulse for a single cycle.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state   <= IDLE;
      rr_ptr  <= 2'd0;
      cur_idx <= 2'd0;
      sreg    <= '0;
      bit_cnt <= '0;
      tick    <= '0;
      gnt     <= 4'b0000;
      done    <= 4'b0000;
      busy    <= 1'b0;
      tx      <= 1'b1;
    end else begin
      gnt  <= 4'b0000;
      done <= 4'b0000;
      case (state)
        IDLE: begin
          tick    <= '0;
          bit_cnt <= '0;
          tx      <= 1'b1;
          if (win_valid) begin
            gnt     <= 4'b0001 << win_idx;
            cur_idx <= win_idx;
            sreg    <= win_data;
            busy    <= 1'b1;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (tick_last) begin
            tick    <= '0;
            tx      <= sreg[0];
            sreg    <= sreg >> 1;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        DATA: begin
          if (tick_last) begin
            tick <= '0;
            if (bit_cnt == BIT_W'(N - 1)) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx      <= sreg[0];
              sreg    <= sreg >> 1;
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        STOP: begin
          if (tick_last) begin
            tick   <= '0;
            busy   <= 1'b0;
            done   <= 4'b0001 << cur_idx;
            rr_ptr <= cur_idx + 2'd1;
            state  <= IDLE;
          end else begin
            tick <= tick + TICK_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter (N=8, CLKS_PER_BIT=4).
module tb_serial_tx_arbiter;

  localparam int unsigned N   = 8;
  localparam int unsigned CPB = 4;

  logic           clk;
  logic           reset_p;
  logic [3:0]     req;
  logic [4*N-1:0] data_flat;
  logic [3:0]     gnt;
  logic [3:0]     done;
  logic           busy;
  logic           tx;

  int checks = 0;
  int errors = 0;

  serial_tx_arbiter #(.N(N), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset_p   (reset_p),
    .req       (req),
    .data_flat (data_flat),
    .gnt       (gnt),
    .done      (done),
    .busy      (busy),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Hold reset for two cycles, then idle one cycle with nothing requested.
  task automatic apply_reset();
    reset_p   = 1'b1;
    req       = 4'b0000;
    data_flat = '0;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
  endtask

  // Step negedges until a grant is visible; returns the number of steps taken.
  task automatic wait_gnt(input int max_cyc, output int waited, output bit ok);
    waited = 0;
    ok     = 1'b0;
    while (waited < max_cyc && !ok) begin
      @(negedge clk);
      waited++;
      if (gnt !== 4'b0000) ok = 1'b1;
    end
  endtask

  // Record one frame starting at the grant sample s0 and ending at sample s40.
  task automatic capture_frame(input bit scramble, output logic [3:0] g,
                               output logic [9:0] bits, output bit stable,
                               output int busy_cnt, output logic [3:0] d,
                               output bit extra, output logic tx_end,
                               output logic busy_end);
    g        = gnt;
    bits     = '0;
    stable   = 1'b1;
    busy_cnt = 0;
    extra    = 1'b0;
    for (int s = 0; s < 40; s++) begin
      if (s > 0) @(negedge clk);
      if ((s % 4) == 0) bits[s / 4] = tx;
      else if (tx !== bits[s / 4]) stable = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (s > 0 && gnt !== 4'b0000) extra = 1'b1;
      if (done !== 4'b0000) extra = 1'b1;
      if (scramble) data_flat = 32'($urandom());
    end
    @(negedge clk);
    d        = done;
    tx_end   = tx;
    busy_end = busy;
    if (gnt !== 4'b0000) extra = 1'b1;
  endtask

  task automatic test_reset();
    reset_p   = 1'b1;
    req       = 4'b1111;
    data_flat = 32'hFFFF_FFFF;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", gnt); end
    checks++;
    if (done !== 4'b0000) begin errors++; $display("FAIL reset_done: got %b expected 0000", done); end
    req     = 4'b0000;
    reset_p = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, busy, gnt, done} !== {1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL idle_outputs: got tx=%b busy=%b gnt=%b done=%b expected 1 0 0000 0000",
               tx, busy, gnt, done);
    end
  endtask

  task automatic test_single();
    int w; bit ok; logic [3:0] g; logic [9:0] bits; bit st; int bc;
    logic [3:0] d; bit ex; logic te; logic be; logic [7:0] word;
    apply_reset();
    word      = 8'hA5;
    req       = 4'b0010;
    data_flat = {8'h00, 8'h00, word, 8'h00};
    wait_gnt(10, w, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL single_gnt_timeout: got none expected 0010");
    end else begin
      capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
      checks++;
      if (g !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b expected 0010", g); end
      checks++;
      if (bits !== {1'b1, word, 1'b0}) begin
        errors++; $display("FAIL single_bits: got %b expected %b", bits, {1'b1, word, 1'b0});
      end
      checks++;
      if (st !== 1'b1) begin errors++; $display("FAIL single_bit_hold: got unstable expected 4-cycle bits"); end
      checks++;
      if (bc != 40) begin errors++; $display("FAIL single_busy_len: got %0d expected 40", bc); end
      checks++;
      if (be !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", be); end
      checks++;
      if (te !== 1'b1) begin errors++; $display("FAIL single_tx_end: got %b expected 1", te); end
      checks++;
      if (d !== 4'b0010) begin errors++; $display("FAIL single_done: got %b expected 0010", d); end
      checks++;
      if (ex !== 1'b0) begin errors++; $display("FAIL single_stray_pulse: got pulse expected none"); end
      req = 4'b0000;
      @(negedge clk);
      checks++;
      if (done !== 4'b0000) begin errors++; $display("FAIL single_done_clear: got %b expected 0000", done); end
    end
  endtask

  task automatic test_back_to_back();
    int w; bit ok; logic [3:0] g; logic [9:0] bits; bit st; int bc;
    logic [3:0] d; bit ex; logic te; logic be; logic [3:0] exp_g;
    logic [7:0] words [4];
    words[0] = 8'h96; words[1] = 8'h5A; words[2] = 8'hC3; words[3] = 8'h3C;
    reset_p   = 1'b1;
    req       = 4'b1111;
    data_flat = {words[3], words[2], words[1], words[0]};
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      wait_gnt(10, w, ok);
      checks++;
      if (ok !== 1'b1 || w != 1) begin
        errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles expected 1", k, w);
      end
      if (ok) begin
        capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
        checks++;
        if (g !== exp_g) begin errors++; $display("FAIL b2b_gnt[%0d]: got %b expected %b", k, g, exp_g); end
        checks++;
        if (bits !== {1'b1, words[k], 1'b0}) begin
          errors++; $display("FAIL b2b_bits[%0d]: got %b expected %b", k, bits, {1'b1, words[k], 1'b0});
        end
        checks++;
        if (d !== exp_g) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected %b", k, d, exp_g); end
        checks++;
        if (te !== 1'b1 || ex !== 1'b0) begin
          errors++; $display("FAIL b2b_gap_idle[%0d]: got tx=%b stray=%b expected tx=1 stray=0", k, te, ex);
        end
        req = req & ~d;
      end
    end
    req = 4'b0000;
    repeat (3) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_quiet: got gnt=%b busy=%b expected 0000 0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int w; bit ok; logic [3:0] g; logic [9:0] bits; bit st; int bc;
    logic [3:0] d; bit ex; logic te; logic be;
    apply_reset();
    req       = 4'b0100;
    data_flat = {8'h11, 8'h3A, 8'h22, 8'h33};
    wait_gnt(10, w, ok);
    if (ok) capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
    checks++;
    if (ok !== 1'b1 || g !== 4'b0100 || d !== 4'b0100) begin
      errors++; $display("FAIL rr_first: got gnt=%b done=%b expected 0100 0100", g, d);
    end
    req = 4'b1001;
    wait_gnt(10, w, ok);
    if (ok) capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
    checks++;
    if (ok !== 1'b1 || g !== 4'b1000) begin
      errors++; $display("FAIL rr_second: got %b expected 1000", g);
    end
    checks++;
    if (bits !== {1'b1, 8'h11, 1'b0}) begin
      errors++; $display("FAIL rr_second_bits: got %b expected %b", bits, {1'b1, 8'h11, 1'b0});
    end
    req = 4'b0001;
    wait_gnt(10, w, ok);
    if (ok) capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
    checks++;
    if (ok !== 1'b1 || g !== 4'b0001 || d !== 4'b0001) begin
      errors++; $display("FAIL rr_third: got gnt=%b done=%b expected 0001 0001", g, d);
    end
    req = 4'b0000;
  endtask

  task automatic test_reset_abort();
    int w; bit ok; logic [3:0] g; logic [9:0] bits; bit st; int bc;
    logic [3:0] d; bit ex; logic te; logic be; bit done_seen;
    apply_reset();
    req       = 4'b0100;
    data_flat = {8'h00, 8'hF0, 8'h00, 8'h81};
    wait_gnt(10, w, ok);
    if (ok) capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
    req = 4'b1000;
    wait_gnt(10, w, ok);
    checks++;
    if (ok !== 1'b1 || gnt !== 4'b1000) begin
      errors++; $display("FAIL abort_pre_gnt: got %b expected 1000", gnt);
    end
    repeat (17) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL abort_mid_data: got tx=%b busy=%b expected 0 1", tx, busy);
    end
    #2;
    reset_p = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL abort_tx: got %b expected 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
    req       = 4'b1001;
    done_seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (done !== 4'b0000) done_seen = 1'b1;
    end
    reset_p = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (done !== 4'b0000) done_seen = 1'b1;
      if (gnt !== 4'b0000) break;
      @(negedge clk);
    end
    checks++;
    if (done_seen !== 1'b0) begin errors++; $display("FAIL abort_no_done: got done pulse expected none"); end
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL abort_ptr_reset: got %b expected 0001", gnt); end
    if (gnt !== 4'b0000) begin
      capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
      checks++;
      if (bits !== {1'b1, 8'h81, 1'b0} || d !== 4'b0001) begin
        errors++; $display("FAIL abort_next_frame: got bits=%b done=%b expected %b 0001",
                           bits, d, {1'b1, 8'h81, 1'b0});
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_data_capture();
    int w; bit ok; logic [3:0] g; logic [9:0] bits; bit st; int bc;
    logic [3:0] d; bit ex; logic te; logic be;
    apply_reset();
    req       = 4'b0010;
    data_flat = {8'h00, 8'h00, 8'h5C, 8'h00};
    wait_gnt(10, w, ok);
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL capture_gnt_timeout: got none expected 0010");
    end else begin
      capture_frame(1'b1, g, bits, st, bc, d, ex, te, be);
      checks++;
      if (bits !== {1'b1, 8'h5C, 1'b0} || st !== 1'b1) begin
        errors++; $display("FAIL capture_bits: got %b stable=%b expected %b stable=1",
                           bits, st, {1'b1, 8'h5C, 1'b0});
      end
      checks++;
      if (d !== 4'b0010) begin errors++; $display("FAIL capture_done: got %b expected 0010", d); end
    end
    req       = 4'b0000;
    data_flat = '0;
  endtask

  task automatic test_rearm();
    int w; bit ok; logic [3:0] g; logic [9:0] bits; bit st; int bc;
    logic [3:0] d; bit ex; logic te; logic be; int n_gnt; int n_done;
    apply_reset();
    req       = 4'b0010;
    data_flat = {8'h00, 8'h00, 8'hE7, 8'h00};
    n_gnt     = 0;
    n_done    = 0;
    for (int f = 0; f < 3; f++) begin
      wait_gnt(10, w, ok);
      checks++;
      if (ok !== 1'b1 || w != 1) begin
        errors++; $display("FAIL rearm_gap[%0d]: got %0d cycles expected 1", f, w);
      end
      if (ok) begin
        capture_frame(1'b0, g, bits, st, bc, d, ex, te, be);
        if (g === 4'b0010) n_gnt++;
        if (d === 4'b0010) n_done++;
        checks++;
        if (bits !== {1'b1, 8'hE7, 1'b0} || te !== 1'b1) begin
          errors++; $display("FAIL rearm_frame[%0d]: got bits=%b tx_end=%b expected %b 1",
                             f, bits, te, {1'b1, 8'hE7, 1'b0});
        end
      end
      if (f == 2) req = 4'b0000;
    end
    checks++;
    if (n_gnt != 3 || n_done != 3) begin
      errors++; $display("FAIL rearm_counts: got gnt=%0d done=%0d expected 3 3", n_gnt, n_done);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || tx !== 1'b1) begin
      errors++; $display("FAIL rearm_idle: got gnt=%b busy=%b tx=%b expected 0000 0 1", gnt, busy, tx);
    end
  endtask

  initial begin
    reset_p   = 1'b1;
    req       = 4'b0000;
    data_flat = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_round_robin();
    test_reset_abort();
    test_data_capture();
    test_rearm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
